// File: rtl/bcd_display_sched.sv
// Time-shared double-dabble binary-to-BCD converter serving N_CH channels round-robin.
// Holds a registered 2-digit BCD image per channel; conversions run on request or refresh tick.
module bcd_display_sched #(
  parameter int N_CH        = 3,
  parameter int W           = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] i_val,
  input  logic [N_CH-1:0]   i_req,
  output logic [N_CH*4-1:0] o_tens,
  output logic [N_CH*4-1:0] o_ones,
  output logic [N_CH-1:0]   o_valid,
  output logic [N_CH-1:0]   o_ovf,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_done_ch,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  localparam int RD = (REFRESH_DIV > 0) ? REFRESH_DIV : 1;
  localparam int CW = (RD > 1) ? $clog2(RD) : 1;
  localparam logic [CW-1:0] TC = CW'(RD - 1);

  logic [1:0]        state_q, state_d;
  logic [N_CH-1:0]   pending_q, pending_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        rr_q, rr_d;
  logic [2:0]        g_q, g_d;
  logic [W-1:0]      snap_q, snap_d;
  logic              sat_q, sat_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [3:0]        wt_q, wt_d, wo_q, wo_d;
  logic [N_CH*4-1:0] tens_q, tens_d, ones_q, ones_d;
  logic [N_CH-1:0]   valid_q, valid_d, ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [2:0]        done_ch_q, done_ch_d;

  logic       tick;
  logic       found;
  logic [2:0] gnt_idx;
  int         arb_idx;
  logic [3:0] adj_t, adj_o;

  // Refresh tick: one cycle at terminal count; disabled entirely when REFRESH_DIV is 0.
  always_comb begin
    tick  = (REFRESH_DIV > 0) && (cnt_q == TC);
    cnt_d = (tick || REFRESH_DIV == 0) ? '0 : cnt_q + 1'b1;
  end

  // Round-robin search starting at rr_q (the channel after the last one served).
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    arb_idx = 0;
    for (int i = 0; i < N_CH; i++) begin
      arb_idx = int'(rr_q) + i;
      if (arb_idx >= N_CH) arb_idx = arb_idx - N_CH;
      if (!found && pending_q[arb_idx]) begin
        found   = 1'b1;
        gnt_idx = 3'(arb_idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | i_req | {N_CH{tick}};
    rr_d      = rr_q;
    g_d       = g_q;
    snap_d    = snap_q;
    sat_d     = sat_q;
    bcnt_d    = bcnt_q;
    wt_d      = wt_q;
    wo_d      = wo_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    done_ch_d = done_ch_q;
    adj_t     = (wt_q >= 4'd5) ? wt_q + 4'd3 : wt_q;
    adj_o     = (wo_q >= 4'd5) ? wo_q + 4'd3 : wo_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          g_d    = gnt_idx;
          wt_d   = '0;
          wo_d   = '0;
          bcnt_d = 3'(W - 1);
          for (int k = 0; k < N_CH; k++) begin
            if (3'(k) == gnt_idx) begin
              snap_d       = i_val[k*W +: W];
              sat_d        = int'(i_val[k*W +: W]) > 99;
              // A same-cycle request for the granted channel queues one more conversion.
              pending_d[k] = i_req[k];
            end
          end
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {wt_d, wo_d} = {adj_t[2:0], adj_o, snap_q[W-1]};
        snap_d       = snap_q << 1;
        if (bcnt_q == 3'd0) state_d = STORE;
        else bcnt_d = bcnt_q - 3'd1;
      end
      STORE: begin
        for (int k = 0; k < N_CH; k++) begin
          if (3'(k) == g_q) begin
            tens_d[k*4 +: 4] = sat_q ? 4'd9 : wt_q;
            ones_d[k*4 +: 4] = sat_q ? 4'd9 : wo_q;
            valid_d[k]       = 1'b1;
            ovf_d[k]         = sat_q;
          end
        end
        done_d    = 1'b1;
        done_ch_d = g_q;
        rr_d      = (g_q == 3'(N_CH - 1)) ? 3'd0 : g_q + 3'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      rr_q      <= '0;
      g_q       <= '0;
      snap_q    <= '0;
      sat_q     <= 1'b0;
      bcnt_q    <= '0;
      wt_q      <= '0;
      wo_q      <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      valid_q   <= '0;
      ovf_q     <= '0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      g_q       <= g_d;
      snap_q    <= snap_d;
      sat_q     <= sat_d;
      bcnt_q    <= bcnt_d;
      wt_q      <= wt_d;
      wo_q      <= wo_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
    end
  end

  assign o_tens      = tens_q;
  assign o_ones      = ones_q;
  assign o_valid     = valid_q;
  assign o_ovf       = ovf_q;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = done_q;
  assign o_done_ch   = done_ch_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bcd_display_sched.sv
// Bench for bcd_display_sched: directed + random requests against a transaction-level
// scheduler model; a negedge monitor pops expected conversions whenever o_done pulses.
module tb_bcd_display_sched;
  localparam int N_CH = 3;
  localparam int W    = 8;

  typedef struct {
    int ch;
    int tens;
    int ones;
    int ovf;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_CH*W-1:0] i_val = '0;
  logic [N_CH-1:0]   i_req = '0;
  logic [N_CH*4-1:0] o_tens, o_ones;
  logic [N_CH-1:0]   o_valid, o_ovf;
  logic              o_busy, o_done;
  logic [2:0]        o_done_ch;
  logic [1:0]        o_dbg_state;

  logic [N_CH*W-1:0] r_i_val;
  logic [N_CH-1:0]   r_i_req;
  logic [N_CH*4-1:0] r_o_tens, r_o_ones;
  logic [N_CH-1:0]   r_o_valid, r_o_ovf;
  logic              r_o_busy, r_o_done;
  logic [2:0]        r_o_done_ch;
  logic [1:0]        r_o_dbg_state;

  bcd_display_sched #(.N_CH(N_CH), .W(W), .REFRESH_DIV(0)) dut (
    .clk(clk), .rst(rst), .i_val(i_val), .i_req(i_req),
    .o_tens(o_tens), .o_ones(o_ones), .o_valid(o_valid), .o_ovf(o_ovf),
    .o_busy(o_busy), .o_done(o_done), .o_done_ch(o_done_ch), .o_dbg_state(o_dbg_state)
  );

  bcd_display_sched #(.N_CH(N_CH), .W(W), .REFRESH_DIV(20)) dut_r (
    .clk(clk), .rst(rst), .i_val(r_i_val), .i_req(r_i_req),
    .o_tens(r_o_tens), .o_ones(r_o_ones), .o_valid(r_o_valid), .o_ovf(r_o_ovf),
    .o_busy(r_o_busy), .o_done(r_o_done), .o_done_ch(r_o_done_ch), .o_dbg_state(r_o_dbg_state)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: pending set, round-robin pointer, converter occupancy timer.
  logic [N_CH-1:0]   m_pend = '0;
  int                m_rr    = 0;
  int                m_timer = 0;
  int                cyc     = 0;
  exp_t              exp_q[$];
  logic [N_CH*4-1:0] sh_tens = '0, sh_ones = '0;
  logic [N_CH-1:0]   sh_valid = '0, sh_ovf = '0;
  bit                mon_en = 0;
  bit                r_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N_CH*W-1:0] pack3(input int a, input int b, input int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  task automatic model_reset();
    m_pend = '0; m_rr = 0; m_timer = 0;
    exp_q.delete();
    sh_tens = '0; sh_ones = '0; sh_valid = '0; sh_ovf = '0;
  endtask

  // Called once per rising edge with the inputs the DUT sampled at that edge.
  task automatic model_step();
    int g;
    int v;
    exp_t e;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    g = -1;
    if (m_timer > 0) m_timer--;
    else if (m_pend != '0) begin
      for (int i = 0; i < N_CH; i++)
        if (g < 0 && m_pend[(m_rr + i) % N_CH]) g = (m_rr + i) % N_CH;
      v      = int'(i_val[g*W +: W]);
      e.ch   = g;
      e.ovf  = (v > 99) ? 1 : 0;
      e.tens = (v > 99) ? 9 : v / 10;
      e.ones = (v > 99) ? 9 : v % 10;
      e.cyc  = cyc + W + 1;
      exp_q.push_back(e);
      m_timer = W + 1;
      m_rr    = (g + 1) % N_CH;
    end
    m_pend = m_pend | i_req;
    if (g >= 0) m_pend[g] = i_req[g];
  endtask

  task automatic step(input logic [N_CH-1:0] req, input logic [N_CH*W-1:0] v);
    i_req = req;
    i_val = v;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, i_val);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tens"}, int'(o_tens), 0);
    chk({tag, "_ones"}, int'(o_ones), 0);
    chk({tag, "_valid"}, int'(o_valid), 0);
    chk({tag, "_ovf"}, int'(o_ovf), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_done_ch"}, int'(o_done_ch), 0);
    chk({tag, "_state"}, int'(o_dbg_state), 0);
  endtask

  // Monitor: busy tracking every cycle, scoreboard pop on every o_done.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      chk("busy", int'(o_busy), (m_timer > 0) ? 1 : 0);
      if (o_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("done_ch", int'(o_done_ch), e.ch);
          chk("done_cycle", cyc, e.cyc);
          sh_tens[e.ch*4 +: 4] = 4'(e.tens);
          sh_ones[e.ch*4 +: 4] = 4'(e.ones);
          sh_valid[e.ch]       = 1'b1;
          sh_ovf[e.ch]         = e.ovf[0];
        end
      end
      chk("tens", int'(o_tens), int'(sh_tens));
      chk("ones", int'(o_ones), int'(sh_ones));
      chk("valid", int'(o_valid), int'(sh_valid));
      chk("ovf", int'(o_ovf), int'(sh_ovf));
    end
  end

  // Refresh-only instance: ticks alone must sweep every channel in round-robin order.
  initial begin
    int cnt;
    int last;
    int exp_t_[3];
    int exp_o_[3];
    exp_t_ = '{2, 4, 0};
    exp_o_ = '{3, 5, 7};
    r_i_val = pack3(23, 45, 7);
    r_i_req = '0;
    cnt  = 0;
    last = 0;
    wait (rst == 1'b0);
    for (int c = 0; c < 200 && cnt < 6; c++) begin
      @(negedge clk);
      if (r_o_done) begin
        chk("r_done_ch", int'(r_o_done_ch), cnt % N_CH);
        chk("r_tens", int'(r_o_tens[(cnt % N_CH)*4 +: 4]), exp_t_[cnt % N_CH]);
        chk("r_ones", int'(r_o_ones[(cnt % N_CH)*4 +: 4]), exp_o_[cnt % N_CH]);
        if (cnt > 0) chk("r_spacing", c - last, W + 2);
        last = c;
        cnt++;
      end
    end
    chk("r_done_count", cnt, 6);
    chk("r_valid_all", int'(r_o_valid), 7);
    chk("r_ovf", int'(r_o_ovf), 0);
    r_done = 1;
  end

  initial begin
    logic [N_CH*W-1:0] v;
    rst = 1'b1;
    step('0, '0);
    step('0, '0);
    check_zero("reset");
    rst = 1'b0;
    mon_en = 1;
    idle(2);

    step(3'b010, pack3(0, 59, 0));
    idle(12);
    chk("t2_tens1", int'(o_tens[7:4]), 5);
    chk("t2_ones1", int'(o_ones[7:4]), 9);

    step(3'b111, pack3(23, 45, 7));
    idle(32);

    step(3'b100, pack3(23, 45, 150));
    idle(12);
    chk("t4_ovf2", int'(o_ovf[2]), 1);
    step(3'b100, pack3(23, 45, 99));
    idle(12);
    chk("t4_ovf2_clear", int'(o_ovf[2]), 0);

    step(3'b001, pack3(12, 45, 99));
    step('0, pack3(12, 45, 99));
    step('0, pack3(12, 45, 99));
    step('0, pack3(34, 45, 99));
    idle(12);
    chk("t5_tens0", int'(o_tens[3:0]), 1);
    chk("t5_ones0", int'(o_ones[3:0]), 2);
    step(3'b001, pack3(34, 45, 99));
    idle(12);
    chk("t5_re_tens0", int'(o_tens[3:0]), 3);

    v = '0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) v = N_CH*W'($urandom);
      step(N_CH'($urandom_range(0, 7) & $urandom_range(0, 7) & $urandom_range(0, 7)), v);
    end

    wait (r_done == 1);
    step(3'b111, v);
    step('0, v);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    step('0, v);
    step('0, v);
    rst = 1'b0;
    idle(15);

    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) v = N_CH*W'($urandom);
      step(N_CH'($urandom_range(0, 7)), v);
    end
    idle(40);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
